buffer_mc: RTL
==============

Name: buffer_mc

Overview:
- Parametrised multi-channel synchronous FIFO. Successor to the single-channel edge-triggered buffer.
- NUM_CH independent queues, each 2^ADDR_L deep. All state updates on one clock edge.
- Adds per-channel occupancy count, almost-full threshold, selectable first-word-fall-through (FWFT) read mode, per-channel flush and sticky overflow/underflow error flags.
- Sits between pipeline stages and memory/IO request paths wherever more than one stream is queued.

Parameters:
- BUF_ID, 0: instance tag, used in simulation $display messages only.
- NUM_CH, 2: number of independent channels (≥1).
- ADDR_L, 5: log2 of depth per channel. DEPTH = 1<<ADDR_L; all DEPTH entries are usable.
- DATA_L, 16: word width.
- AF_LVL, DEPTH-2: almost_full asserts when count ≥ AF_LVL.
- FWFT, 0: read mode. 0 = registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset; asynchronous, active-low.
- clr  in  NUM_CH  synchronous per-channel flush.
- we  in  NUM_CH  per-channel write request; level, sampled each posedge.
- re  in  NUM_CH  per-channel read request; level, sampled each posedge.
- din  in  NUM_CH*DATA_L  packed write data; channel c occupies bits [c*DATA_L +: DATA_L].
- dout  out  NUM_CH*DATA_L  packed read data.
- w_ack  out  NUM_CH  write accepted, one-cycle pulse.
- r_ack  out  NUM_CH  read accepted, one-cycle pulse.
- avail  out  NUM_CH  count != 0.
- full  out  NUM_CH  count == DEPTH.
- almost_full  out  NUM_CH  count ≥ AF_LVL.
- count  out  NUM_CH*(ADDR_L+1)  packed occupancy.
- ovf  out  NUM_CH  sticky overflow.
- udf  out  NUM_CH  sticky underflow.

Behaviour:

Reset (rst low, asynchronous):
- Pointers and counts go to 0; dout, w_ack, r_ack, ovf and udf go to 0.
- avail=0, full=0; almost_full=0 unless AF_LVL==0.
- Storage array is not cleared.
- Reset asserted mid-operation discards all contents immediately. The first cycle after deassertion behaves as empty.

Pointers and count:
- Per channel: rpt and wpt are ADDR_L bits and wrap modulo DEPTH.
- count is ADDR_L+1 bits, so full is distinguishable from empty.
- avail, full and almost_full are combinational from count.

Write (per channel, each posedge):
- Accepted iff we & ~full, using full as it was before the edge.
- On accept: data[wpt]<=din, wpt++, and w_ack=1 in the next cycle.
- On reject: ovf<=1, w_ack=0, contents unchanged. A $display error message carries BUF_ID, channel, wpt and rpt.
- Write is rejected when full even if a read is accepted on the same edge.

Read (per channel, each posedge):
- Accepted iff re & avail, using avail as it was before the edge.
- On accept: rpt++ and r_ack=1 in the next cycle.
- On reject: udf<=1, r_ack=0, pointers unchanged.
- Read is rejected when empty even if a write is accepted on the same edge.

Read data per mode:
- FWFT=0: on an accepted read, dout<=data[rpt], valid in the same cycle as r_ack. dout holds until the next accepted read. A rejected read leaves dout unchanged.
- FWFT=1: dout = data[rpt] combinationally whenever avail=1 (0 when empty). The read pops the head. r_ack timing is the same as FWFT=0.

Simultaneous events:
- Accepted read and accepted write on one edge: count unchanged, both acks pulse.
- Continuous we or re held high gives one transfer per cycle, acks high every accepted cycle.

Flush (clr[c] high at a posedge):
- rpt, wpt, count, ovf and udf of channel c go to 0. w_ack and r_ack of c go to 0.
- clr has priority over we/re in the same cycle. Other channels are unaffected.

Channel independence:
- No cross-channel interaction or arbitration.
- The generate loop over NUM_CH must reproduce single-channel behaviour exactly at NUM_CH=1.

Width rules:
- count increments and decrements at ADDR_L+1 bits and never exceeds DEPTH.
- AF_LVL values greater than DEPTH make almost_full a duplicate of full.

Test Plan:
All scenarios use NUM_CH=2, ADDR_L=2 (DEPTH=4), DATA_L=16, AF_LVL=2, FWFT=0 unless stated.
1. Reset then fill channel 0 with 0x11,0x22,0x33,0x44 on consecutive cycles -> w_ack[0] high 4 cycles; count0 goes 1,2,3,4; almost_full[0] rises at count 2; full[0]=1 after the 4th write; channel 1 count stays 0.
2. From full, write 0x55 -> no w_ack, ovf[0]=1 sticky, count0 stays 4. Then 4 reads -> dout 0x11,0x22,0x33,0x44 each with r_ack; avail[0]=0 at the end. A 5th read -> udf[0]=1, dout stays 0x44.
3. With count0=4, hold we and re together for 1 cycle -> read accepted, write rejected, count0=3, ovf set. With count0=0, same stimulus -> write accepted, read rejected, count0=1, udf set.
4. Wrap-around: stream 10 words (0x1..0xA) with overlapped we/re at count 2 -> output order 0x1..0xA intact across pointer wrap, count never exceeds 4.
5. FWFT=1: write 0xBEEF into empty channel 1 -> dout[ch1]=0xBEEF in the cycle after write with no re; re pops it, then dout=0 and avail[1]=0.
6. clr[0] while count0=3 with we[0]=1 the same cycle -> count0=0, ovf/udf cleared, no w_ack; channel 1 contents intact. Asynchronous rst pulse mid-stream -> all outputs 0 immediately, next write lands at count 1.

Source files
------------

// File: rtl/buffer_mc_if.sv
// Bundle of per-channel request, data and status signals for buffer_mc.
// The FIFO takes the slave view; whatever drives the queues takes the master view.
interface buffer_mc_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_L = 5,
    parameter int DATA_L = 16
);
    logic [NUM_CH-1:0]            clr;
    logic [NUM_CH-1:0]            we;
    logic [NUM_CH-1:0]            re;
    logic [NUM_CH*DATA_L-1:0]     din;
    logic [NUM_CH*DATA_L-1:0]     dout;
    logic [NUM_CH-1:0]            w_ack;
    logic [NUM_CH-1:0]            r_ack;
    logic [NUM_CH-1:0]            avail;
    logic [NUM_CH-1:0]            full;
    logic [NUM_CH-1:0]            almost_full;
    logic [NUM_CH*(ADDR_L+1)-1:0] count;
    logic [NUM_CH-1:0]            ovf;
    logic [NUM_CH-1:0]            udf;

    modport master (
        output clr, we, re, din,
        input  dout, w_ack, r_ack, avail, full, almost_full, count, ovf, udf
    );

    modport slave (
        input  clr, we, re, din,
        output dout, w_ack, r_ack, avail, full, almost_full, count, ovf, udf
    );
endinterface

// File: rtl/buffer_mc.sv
// Multi-channel synchronous FIFO: NUM_CH independent queues of 2^ADDR_L words with
// occupancy, almost-full, sticky error flags, per-channel flush and optional FWFT reads.
module buffer_mc #(
    parameter int BUF_ID = 0,
    parameter int NUM_CH = 2,
    parameter int ADDR_L = 5,
    parameter int DATA_L = 16,
    parameter int AF_LVL = (1 << ADDR_L) - 2,
    parameter int FWFT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    buffer_mc_if.slave  bus
);

    localparam int DEPTH    = 1 << ADDR_L;
    localparam int CW       = ADDR_L + 1;
    // Thresholds above DEPTH can never be reached, so clamp them to behave like full.
    localparam int AF_CLAMP = (AF_LVL > DEPTH) ? DEPTH : ((AF_LVL < 0) ? 0 : AF_LVL);

    localparam logic [CW-1:0]     AF_THR   = CW'(AF_CLAMP);
    localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [ADDR_L-1:0] PTR_ONE  = ADDR_L'(1);

    generate
        if (NUM_CH < 1 || BUF_ID < 0) begin : g_param_err
            $error("buffer_mc %0d: NUM_CH must be >= 1", BUF_ID);
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_L-1:0] mem [DEPTH];

            logic [ADDR_L-1:0] wpt_reg, wpt_next;
            logic [ADDR_L-1:0] rpt_reg, rpt_next;
            logic [CW-1:0]     cnt_reg, cnt_next;
            logic [DATA_L-1:0] dout_reg, dout_next;
            logic              w_ack_reg, w_ack_next;
            logic              r_ack_reg, r_ack_next;
            logic              ovf_reg, ovf_next;
            logic              udf_reg, udf_next;

            logic              clr_c, we_c, re_c;
            logic              avail_c, full_c;
            logic              wr_ok, rd_ok;
            logic [DATA_L-1:0] din_c, head, dout_c;

            assign clr_c   = bus.clr[gi];
            assign we_c    = bus.we[gi];
            assign re_c    = bus.re[gi];
            assign din_c   = bus.din[gi*DATA_L +: DATA_L];

            assign avail_c = (cnt_reg != '0);
            assign full_c  = (cnt_reg == FULL_CNT);

            // Acceptance looks only at pre-edge status, so a same-edge read never
            // makes room for a write on a full queue (and vice versa when empty).
            assign wr_ok   = we_c & ~full_c  & ~clr_c;
            assign rd_ok   = re_c & avail_c  & ~clr_c;
            assign head    = mem[rpt_reg];

            always_comb begin
                wpt_next   = wpt_reg;
                rpt_next   = rpt_reg;
                cnt_next   = cnt_reg;
                dout_next  = dout_reg;
                ovf_next   = ovf_reg;
                udf_next   = udf_reg;
                w_ack_next = wr_ok;
                r_ack_next = rd_ok;
                if (clr_c) begin
                    wpt_next = '0;
                    rpt_next = '0;
                    cnt_next = '0;
                    ovf_next = 1'b0;
                    udf_next = 1'b0;
                end else begin
                    if (wr_ok) begin
                        wpt_next = wpt_reg + PTR_ONE;
                    end
                    if (rd_ok) begin
                        rpt_next  = rpt_reg + PTR_ONE;
                        dout_next = head;
                    end
                    if (we_c & full_c) begin
                        ovf_next = 1'b1;
                    end
                    if (re_c & ~avail_c) begin
                        udf_next = 1'b1;
                    end
                    case ({wr_ok, rd_ok})
                        2'b10:   cnt_next = cnt_reg + CNT_ONE;
                        2'b01:   cnt_next = cnt_reg - CNT_ONE;
                        default: cnt_next = cnt_reg;
                    endcase
                end
            end

            // Storage has no reset so it can map onto block or distributed RAM.
            always_ff @(posedge clk) begin
                if (wr_ok) begin
                    mem[wpt_reg] <= din_c;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wpt_reg   <= '0;
                    rpt_reg   <= '0;
                    cnt_reg   <= '0;
                    dout_reg  <= '0;
                    w_ack_reg <= 1'b0;
                    r_ack_reg <= 1'b0;
                    ovf_reg   <= 1'b0;
                    udf_reg   <= 1'b0;
                end else begin
                    wpt_reg   <= wpt_next;
                    rpt_reg   <= rpt_next;
                    cnt_reg   <= cnt_next;
                    dout_reg  <= dout_next;
                    w_ack_reg <= w_ack_next;
                    r_ack_reg <= r_ack_next;
                    ovf_reg   <= ovf_next;
                    udf_reg   <= udf_next;
                end
            end

            if (FWFT != 0) begin : g_fwft
                assign dout_c = avail_c ? head : '0;
            end else begin : g_reg_rd
                assign dout_c = dout_reg;
            end

            assign bus.dout[gi*DATA_L +: DATA_L] = dout_c;
            assign bus.count[gi*CW +: CW]        = cnt_reg;
            assign bus.w_ack[gi]                 = w_ack_reg;
            assign bus.r_ack[gi]                 = r_ack_reg;
            assign bus.avail[gi]                 = avail_c;
            assign bus.full[gi]                  = full_c;
            assign bus.almost_full[gi]           = (cnt_reg >= AF_THR);
            assign bus.ovf[gi]                   = ovf_reg;
            assign bus.udf[gi]                   = udf_reg;
        end
    endgenerate

endmodule
